// File: rtl/stream_mux_pkg.sv
// rtl/stream_mux_pkg.sv - shared types and default constants for stream_mux_n
//
// Purpose : mode encoding, output-stage state encoding and the default
//           parameter values used by stream_mux_n and rr_arbiter.
// Ports   : none (package).

package stream_mux_pkg;

    localparam int DEF_N_CH   = 8;
    localparam int DEF_DATA_W = 8;
    localparam int STATS_W    = 16;

    typedef enum logic {
        MODE_FIXED = 1'b0,
        MODE_RR    = 1'b1
    } mux_mode_e;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin grant search and priority pointer
//
// Purpose : picks the first requesting channel searching upward from
//           (rr_ptr + 1) mod N, wrapping at N-1. The pointer moves to the
//           granted index only when the caller reports a real transfer.
// Ports   : clk, rst        clock, synchronous active-high reset
//           i_req[N]        per-channel request (in_valid)
//           i_upd           grant was consumed this cycle; advance pointer
//           o_gnt_vld       some channel requests
//           o_gnt_idx       index of the winning channel

module rr_arbiter
    import stream_mux_pkg::*;
#(
    parameter  int N     = DEF_N_CH,
    localparam int SEL_W = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_upd,
    output logic             o_gnt_vld,
    output logic [SEL_W-1:0] o_gnt_idx
);

    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W:0]   w_pos;
    logic [SEL_W-1:0] w_idx;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt_idx;

    // Reset to N-1 so that channel 0 is the first candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= SEL_W'(N - 1);
        end else if (i_upd) begin
            r_ptr <= w_gnt_idx;
        end
    end

    // One extra bit on w_pos holds r_ptr + k (max 2N-1) before the wrap.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        w_pos     = '0;
        w_idx     = '0;
        for (int k = 1; k <= N; k++) begin
            w_pos = {1'b0, r_ptr} + (SEL_W + 1)'(k);
            if (w_pos >= (SEL_W + 1)'(N)) begin
                w_pos = w_pos - (SEL_W + 1)'(N);
            end
            w_idx = w_pos[SEL_W-1:0];
            if (!w_gnt_vld && i_req[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
    end

    assign o_gnt_vld = w_gnt_vld;
    assign o_gnt_idx = w_gnt_idx;

endmodule

// File: rtl/stream_mux_n.sv
// rtl/stream_mux_n.sv - N-channel stream multiplexer with one-entry output register
//
// Purpose : selects one input channel per cycle (fixed by sel, or round-robin)
//           into a registered output stage with valid/ready handshake.
// Ports   : clk, rst                 clock, synchronous active-high reset
//           mode                    0 = fixed select, 1 = round-robin
//           sel[SEL_W]              channel index in fixed mode
//           in_valid/in_ready[N_CH] per-channel handshake
//           in_data[N_CH*DATA_W]    channel i at [i*DATA_W +: DATA_W]
//           out_valid/out_ready     output handshake
//           out_data[DATA_W]        registered selected data
//           out_ch[SEL_W]           channel that supplied out_data
//           xfer_cnt[16]            saturating output-transfer count, present
//                                   only when STREAM_MUX_STATS_EN is defined

module stream_mux_n
    import stream_mux_pkg::*;
#(
    parameter  int N_CH   = DEF_N_CH,
    parameter  int DATA_W = DEF_DATA_W,
    localparam int SEL_W  = $clog2(N_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [N_CH-1:0]          in_valid,
    input  logic [N_CH*DATA_W-1:0]   in_data,
    output logic [N_CH-1:0]          in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
`ifdef STREAM_MUX_STATS_EN
    ,
    output logic [STATS_W-1:0]       xfer_cnt
`endif
);

    mux_mode_e        w_mode;
    out_state_e       r_state;
    out_state_e       w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [SEL_W-1:0] r_ch;

    logic             w_load_en;
    logic             w_fix_vld;
    logic [SEL_W-1:0] w_fix_idx;
    logic             w_rr_vld;
    logic [SEL_W-1:0] w_rr_idx;
    logic             w_gnt_vld;
    logic [SEL_W-1:0] w_gnt_idx;
    logic             w_in_xfer;
    logic             w_out_xfer;
    logic             w_rr_upd;
    logic [DATA_W-1:0] w_sel_data;

    assign w_mode     = mux_mode_e'(mode);
    assign out_valid  = (r_state == OUT_FULL);
    assign w_load_en  = !out_valid || out_ready;
    assign w_out_xfer = out_valid && out_ready;

    // Fixed select: an out-of-range sel (possible when N_CH is not a power
    // of two) simply matches no channel, so no grant is issued.
    always_comb begin
        w_fix_vld = 1'b0;
        w_fix_idx = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (sel == SEL_W'(i) && in_valid[i]) begin
                w_fix_vld = 1'b1;
                w_fix_idx = SEL_W'(i);
            end
        end
    end

    // Pointer moves only on a round-robin transfer; fixed-mode traffic and
    // stalled cycles leave the fairness order untouched.
    assign w_rr_upd = (w_mode == MODE_RR) && w_in_xfer;

    rr_arbiter #(
        .N (N_CH)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst       (rst),
        .i_req     (in_valid),
        .i_upd     (w_rr_upd),
        .o_gnt_vld (w_rr_vld),
        .o_gnt_idx (w_rr_idx)
    );

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = '0;
        if (w_mode == MODE_RR) begin
            w_gnt_vld = w_rr_vld;
            w_gnt_idx = w_rr_idx;
        end else begin
            w_gnt_vld = w_fix_vld;
            w_gnt_idx = w_fix_idx;
        end
    end

    // The grant only ever goes to a valid channel, so granting while the
    // output can load is exactly an input transfer.
    assign w_in_xfer = !rst && w_gnt_vld && w_load_en;

    // in_ready is built from the grant only; in_data never feeds it.
    always_comb begin
        in_ready = '0;
        if (!rst && w_gnt_vld) begin
            in_ready[w_gnt_idx] = w_load_en;
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (w_gnt_idx == SEL_W'(i)) begin
                w_sel_data = in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= OUT_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            OUT_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (w_out_xfer && !w_in_xfer) begin
                    w_state_nxt = OUT_EMPTY;
                end
            end
            default: w_state_nxt = OUT_EMPTY;
        endcase
    end

    // Payload only loads on an input transfer, so it holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data <= '0;
            r_ch   <= '0;
        end else if (w_in_xfer) begin
            r_data <= w_sel_data;
            r_ch   <= w_gnt_idx;
        end
    end

    assign out_data = r_data;
    assign out_ch   = r_ch;

`ifdef STREAM_MUX_STATS_EN
    logic [STATS_W-1:0] r_xfer_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xfer_cnt <= '0;
        end else if (w_out_xfer && (r_xfer_cnt != {STATS_W{1'b1}})) begin
            r_xfer_cnt <= r_xfer_cnt + 1'b1;
        end
    end

    assign xfer_cnt = r_xfer_cnt;
`endif

endmodule

// File: tb/tb_stream_mux_n.sv
// tb/tb_stream_mux_n.sv - directed self-checking bench for stream_mux_n

module tb_stream_mux_n;

    logic        clk;
    logic        rst;

    logic        mode;
    logic [2:0]  sel;
    logic [7:0]  in_valid;
    logic [63:0] in_data;
    logic [7:0]  in_ready;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_ch;
    logic        out_ready;

    logic        mode_b;
    logic [1:0]  sel_b;
    logic [2:0]  in_valid_b;
    logic [23:0] in_data_b;
    logic [2:0]  in_ready_b;
    logic        out_valid_b;
    logic [7:0]  out_data_b;
    logic [1:0]  out_ch_b;
    logic        out_ready_b;

`ifdef STREAM_MUX_STATS_EN
    logic [15:0] xfer_cnt;
    logic [15:0] xfer_cnt_b;
`endif

    int n_chk;
    int n_fail;

    stream_mux_n #(.N_CH(8), .DATA_W(8)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_ready (out_ready)
`ifdef STREAM_MUX_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    stream_mux_n #(.N_CH(3), .DATA_W(8)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode_b),
        .sel       (sel_b),
        .in_valid  (in_valid_b),
        .in_data   (in_data_b),
        .in_ready  (in_ready_b),
        .out_valid (out_valid_b),
        .out_data  (out_data_b),
        .out_ch    (out_ch_b),
        .out_ready (out_ready_b)
`ifdef STREAM_MUX_STATS_EN
        ,
        .xfer_cnt  (xfer_cnt_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] chdata(input int i);
        return (i == 3) ? 8'hA5 : 8'(16 * i + 1);
    endfunction

    initial begin
        int seq [3];
        n_chk  = 0;
        n_fail = 0;

        for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = chdata(i);
        rst         = 1'b1;
        mode        = 1'b0;
        sel         = 3'd0;
        in_valid    = 8'hFF;
        out_ready   = 1'b1;
        mode_b      = 1'b0;
        sel_b       = 2'd0;
        in_valid_b  = 3'b000;
        in_data_b   = 24'h33_22_11;
        out_ready_b = 1'b1;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_data", out_data, 8'h00);
        chk("rst_out_ch", out_ch, 3'd0);
        chk("rst_in_ready", in_ready, 8'h00);

        // Fixed select, sel = 3
        rst  = 1'b0;
        mode = 1'b0;
        sel  = 3'd3;
        #1;
        chk("fix_in_ready", in_ready, 8'h08);
        tick();
        chk("fix_out_valid", out_valid, 1'b1);
        chk("fix_out_data", out_data, 8'hA5);
        chk("fix_out_ch", out_ch, 3'd3);

        // Round-robin from a pointer untouched by fixed-mode traffic
        mode = 1'b1;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("rr_in_ready", in_ready, 32'(1 << (k % 8)));
            tick();
            chk("rr_out_valid", out_valid, 1'b1);
            chk("rr_out_ch", out_ch, 32'(k % 8));
            chk("rr_out_data", out_data, chdata(k % 8));
        end

        // Make the last grant 7, then sparse request with wrap
        in_valid = 8'h80;
        #1;
        chk("pre7_in_ready", in_ready, 8'h80);
        tick();
        chk("pre7_out_ch", out_ch, 3'd7);
        in_valid = 8'b1000_0010;
        seq = '{1, 7, 1};
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("sparse_out_ch", out_ch, 32'(seq[k]));
            chk("sparse_out_data", out_data, chdata(seq[k]));
        end

        // Backpressure while FULL holding channel 1
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        #1;
        chk("bp_in_ready", in_ready, 8'h00);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_out_ch", out_ch, 3'd1);
            chk("bp_out_data", out_data, chdata(1));
            chk("bp_in_ready_hold", in_ready, 8'h00);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_rel_in_ready", in_ready, 8'h04);
        tick();
        chk("bp_rel_out_ch", out_ch, 3'd2);
        #1;
        chk("bp_rel_in_ready2", in_ready, 8'h08);
        tick();
        chk("bp_rel_out_ch2", out_ch, 3'd3);

        // Drain: output transfer with no input transfer
        in_valid = 8'h00;
        #1;
        chk("drain_in_ready", in_ready, 8'h00);
        tick();
        chk("drain_out_valid", out_valid, 1'b0);

        // EMPTY accepts even with out_ready low
        in_valid  = 8'hFF;
        out_ready = 1'b0;
        #1;
        chk("empty_in_ready", in_ready, 8'h10);
        tick();
        chk("empty_out_valid", out_valid, 1'b1);
        chk("empty_out_ch", out_ch, 3'd4);
        #1;
        chk("full_stall_in_ready", in_ready, 8'h00);

        // Reset while FULL discards the word and restarts at channel 0
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 8'h00);
        tick();
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_out_data", out_data, 8'h00);
        chk("midrst_out_ch", out_ch, 3'd0);
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("postrst_in_ready", in_ready, 8'h01);
        tick();
        chk("postrst_out_ch", out_ch, 3'd0);
        chk("postrst_out_data", out_data, chdata(0));

        // Three-channel instance: sel = 3 is out of range
        mode_b     = 1'b0;
        sel_b      = 2'd3;
        in_valid_b = 3'b111;
        #1;
        chk("n3_bad_sel_in_ready", in_ready_b, 3'b000);
        tick();
        chk("n3_bad_sel_out_valid", out_valid_b, 1'b0);
        sel_b = 2'd2;
        #1;
        chk("n3_sel2_in_ready", in_ready_b, 3'b100);
        tick();
        chk("n3_sel2_out_valid", out_valid_b, 1'b1);
        chk("n3_sel2_out_ch", out_ch_b, 2'd2);
        chk("n3_sel2_out_data", out_data_b, 8'h33);

`ifdef STREAM_MUX_STATS_EN
        rst = 1'b1;
        tick();
        chk("stats_rst", xfer_cnt, 16'h0000);
        rst       = 1'b0;
        mode      = 1'b1;
        in_valid  = 8'hFF;
        out_ready = 1'b1;
        repeat (5) tick();
        chk("stats_small", xfer_cnt, 16'd4);
        repeat (70000) tick();
        chk("stats_sat", xfer_cnt, 16'hFFFF);
        rst = 1'b1;
        tick();
        chk("stats_clr", xfer_cnt, 16'h0000);
        rst = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/stream_mux_n.md
STREAM_MUX_N -- requirements
Module: stream_mux_n

Interface
REQ-001 Parameter N_CH, default 8: number of input channels, legal 2..32.
REQ-002 Parameter DATA_W, default 8: data width per channel, legal 1..64.
REQ-003 Localparam SEL_W = $clog2(N_CH): channel index width.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  input  1  clock; all state SHALL update on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 mode  input  1  0 = fixed select via sel, 1 = round-robin arbitration.
REQ-008 sel  input  SEL_W  channel index used when mode = 0.
REQ-009 in_valid  input  N_CH  per-channel data valid.
REQ-010 in_data  input  N_CH*DATA_W  packed channel data; channel i occupies bits [i*DATA_W +: DATA_W].
REQ-011 in_ready  output  N_CH  per-channel accept.
REQ-012 out_valid  output  1  output register holds data.
REQ-013 out_data  output  DATA_W  registered selected data.
REQ-014 out_ch  output  SEL_W  index of the channel that supplied out_data.
REQ-015 out_ready  input  1  downstream accept.

Function
REQ-016 Transfer on channel i SHALL occur when in_valid[i] && in_ready[i] are both high at a rising edge; the output transfer SHALL occur when out_valid && out_ready are both high.
REQ-017 The output stage SHALL be a one-entry register with states EMPTY (out_valid = 0) and FULL (out_valid = 1); load_en = !out_valid || out_ready.
REQ-018 The output stage SHALL make these transitions: EMPTY->FULL on input transfer; FULL->EMPTY on output transfer without input transfer; FULL->FULL on simultaneous input and output transfer (new data replaces old).
REQ-019 Exactly one channel at most SHALL be granted per cycle, and in_ready SHALL be asserted only on the granted channel: in_ready[g] = load_en.
REQ-020 With mode = 0, grant SHALL go to sel when in_valid[sel] = 1; if sel >= N_CH, no grant is issued and in_ready SHALL be all zero.
REQ-021 With mode = 1, grant SHALL go to the first valid channel searching upward from (rr_ptr+1) mod N_CH, wrapping from N_CH-1 to 0.
REQ-022 rr_ptr SHALL update to the granted index only on an input transfer; stalls (load_en = 0) and mode = 0 transfers SHALL leave rr_ptr unchanged.
REQ-023 Latency SHALL be 1 cycle: data accepted at edge k appears on out_data/out_ch after edge k.
REQ-024 out_data and out_ch SHALL hold stable while out_valid && !out_ready.
REQ-025 mode and sel SHALL be sampled every cycle with no internal lock; a change takes effect on the next grant.
REQ-026 in_ready SHALL depend combinationally on in_valid, mode, sel, out_valid, out_ready and rr_ptr only; there SHALL be no combinational path from in_data.

Reset
REQ-027 While rst = 1: out_valid = 0, out_data = 0, out_ch = 0, rr_ptr = N_CH-1 (so channel 0 wins first), in_ready = all zero.
REQ-028 Reset asserted mid-operation SHALL discard any held output word without an output transfer.

Configuration
REQ-029 Macro STREAM_MUX_STATS_EN: when defined, the block SHALL add output xfer_cnt (16 bits) counting output transfers, saturating at 16'hFFFF, and cleared to 0 by rst.
REQ-030 When STREAM_MUX_STATS_EN is undefined, the xfer_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 Package stream_mux_pkg SHALL hold typedef enum logic {MODE_FIXED = 0, MODE_RR = 1} mux_mode_e and the default-parameter constants.
REQ-032 Sub-module rr_arbiter #(N) SHALL contain the round-robin grant logic and rr_ptr; the output register SHALL live in stream_mux_n.

Verification (N_CH = 8, DATA_W = 8)
REQ-033 Fixed select: mode = 0, sel = 3, in_valid = 8'hFF, ch3 data = 8'hA5, out_ready = 1 -> in_ready = 8'h08; next cycle out_valid = 1, out_data = 8'hA5, out_ch = 3.
REQ-034 Round-robin fairness: mode = 1, in_valid = 8'hFF, out_ready = 1 from reset -> out_ch sequence 0,1,2,...,7,0, one word per cycle.
REQ-035 Sparse and wrap: mode = 1, in_valid = 8'b1000_0010, last grant = 7 -> next grants are 1, then 7, then 1.
REQ-036 Backpressure: out_ready = 0 for 3 cycles while FULL -> in_ready = 0, out_data/out_ch stable, rr_ptr unchanged; release -> the same grant order resumes.
REQ-037 Invalid sel and reset: mode = 0, sel = 3 with N_CH = 3 -> no grant. rst pulsed while FULL -> out_valid = 0 next cycle, and the first grant after reset is channel 0.
REQ-038 Stats (macro defined): 70000 back-to-back transfers -> xfer_cnt = 16'hFFFF; rst -> xfer_cnt = 0.
